// File: rtl/i2c_slave.sv
// I2C target with a small byte-wide register bank. SCL/SDA are oversampled on
// clk; SDA is driven open-drain through sda_oe and SCL is never stretched.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         NREGS       = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_oe,
  output logic [8*NREGS-1:0]       regs_out,
  output logic                     wr_strobe,
  output logic [$clog2(NREGS)-1:0] wr_index,
  output logic                     busy
);

  localparam int PW = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK, S_PTR, S_WDATA, S_RDATA, S_WAIT
  } state_t;

  state_t                 r_state;
  state_t                 r_ack_next;
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic [7:0]             r_shift;
  logic [3:0]             r_bitcnt;
  logic                   r_nack;
  logic                   r_commit;
  logic [PW-1:0]          r_ptr;
  logic [7:0]             r_regs [NREGS];
  logic                   r_sda_oe;
  logic                   r_wr_strobe;
  logic [PW-1:0]          r_wr_index;
  logic                   r_busy;

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;
  logic [7:0] w_rd_byte;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_rd_byte  = r_regs[r_ptr];

  assign sda_oe    = r_sda_oe;
  assign wr_strobe = r_wr_strobe;
  assign wr_index  = r_wr_index;
  assign busy      = r_busy;

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign regs_out[8*g +: 8] = r_regs[g];
  end

  // Synchronizers plus one registered copy for edge detection; idle bus is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync[0] <= scl_in;
      r_sda_sync[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_scl_sync[i] <= r_scl_sync[i-1];
        r_sda_sync[i] <= r_sda_sync[i-1];
      end
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ack_next  <= S_IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_nack      <= 1'b0;
      r_commit    <= 1'b0;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_index  <= '0;
      r_busy      <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_commit    <= 1'b0;
      // A completed write byte lands one clk after its 8th SCL rise.
      if (r_commit) begin
        r_regs[r_ptr] <= r_shift;
        r_wr_strobe   <= 1'b1;
        r_wr_index    <= r_ptr;
        r_ptr         <= r_ptr + PW'(1);
      end
      if (w_start) begin
        r_state  <= S_ADDR;
        r_bitcnt <= '0;
        r_sda_oe <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte;
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                r_bitcnt <= '0;
                case (r_state)
                  S_ADDR: begin
                    if (w_byte[7:1] == SLAVE_ADDR) begin
                      r_busy     <= 1'b1;
                      r_state    <= S_ACK;
                      r_ack_next <= w_byte[0] ? S_RDATA : S_PTR;
                    end else begin
                      r_busy  <= 1'b0;
                      r_state <= S_IDLE;
                    end
                  end
                  S_PTR: begin
                    r_ptr      <= w_byte[PW-1:0];
                    r_state    <= S_ACK;
                    r_ack_next <= S_WDATA;
                  end
                  default: begin
                    r_commit   <= 1'b1;
                    r_state    <= S_ACK;
                    r_ack_next <= S_WDATA;
                  end
                endcase
              end
            end
          end
          // First fall after the byte pulls SDA low, the second one ends the ACK.
          S_ACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else if (r_ack_next == S_RDATA) begin
                r_shift  <= w_rd_byte;
                r_sda_oe <= ~w_rd_byte[7];
                r_ptr    <= r_ptr + PW'(1);
                r_bitcnt <= '0;
                r_state  <= S_RDATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= r_ack_next;
              end
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              if (r_bitcnt == 4'd8) begin
                r_nack   <= w_sda;
                r_bitcnt <= 4'd9;
              end else begin
                r_bitcnt <= r_bitcnt + 4'd1;
              end
            end else if (w_scl_fall) begin
              if (r_bitcnt == 4'd9) begin
                if (r_nack) begin
                  r_sda_oe <= 1'b0;
                  r_state  <= S_WAIT;
                end else begin
                  r_shift  <= w_rd_byte;
                  r_sda_oe <= ~w_rd_byte[7];
                  r_ptr    <= r_ptr + PW'(1);
                  r_bitcnt <= '0;
                end
              end else if (r_bitcnt == 4'd8) begin
                r_sda_oe <= 1'b0;
              end else if (r_bitcnt != 4'd0) begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          default: r_sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged master plus a transaction-level model of
// the register bank, pointer and expected SDA drive, checked every SCL slot.
module tb_i2c_slave;
  localparam int         NREGS  = 4;
  localparam logic [6:0] SADDR  = 7'h50;
  localparam int         Q      = 8;
  localparam int         K_ADDR = 0;
  localparam int         K_PTR  = 1;
  localparam int         K_DATA = 2;
  localparam int         K_NONE = 3;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  wire         sda_bus;
  logic        sda_oe;
  logic        wr_strobe;
  logic        busy;
  logic [31:0] regs_out;
  logic [1:0]  wr_index;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave #(.SLAVE_ADDR(SADDR), .NREGS(NREGS), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oe(sda_oe), .regs_out(regs_out), .wr_strobe(wr_strobe),
    .wr_index(wr_index), .busy(busy)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acks   = 0;
  logic [7:0] m_regs [NREGS];
  int   m_ptr;
  logic m_busy;
  logic m_oe;
  logic m_quiet;
  logic chk_slot;
  int   exp_idx [$];
  int   seen_idx [$];

  function automatic void chk(input logic ok, input string name,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mpack();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  always @(negedge clk) begin
    int e;
    if (reset) begin
      if (wr_strobe === 1'b1) begin
        seen_idx.push_back(int'(wr_index));
        chk(exp_idx.size() != 0, "wr_strobe_expected", 32'd1, 32'(exp_idx.size()));
        if (exp_idx.size() != 0) begin
          e = exp_idx.pop_front();
          chk(int'(wr_index) == e, "wr_index", 32'(wr_index), 32'(e));
        end
      end
      if (chk_slot) begin
        chk(sda_oe === m_oe, "slot_sda_oe", 32'(sda_oe), 32'(m_oe));
        chk(busy === m_busy, "slot_busy", 32'(busy), 32'(m_busy));
        chk(regs_out === mpack(), "slot_regs_out", regs_out, mpack());
      end
      if (m_quiet) chk(sda_oe === 1'b0, "quiet_sda_oe", 32'(sda_oe), 32'd0);
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period starting just after a fall: set SDA, check, rise, sample, fall.
  task automatic bit_slot(input logic drv, input logic eoe, output logic rb);
    wclk(Q);
    sda_m    = drv;
    m_oe     = eoe;
    chk_slot = 1'b1;
    wclk(1);
    chk_slot = 1'b0;
    wclk(Q - 1);
    scl_m = 1'b1;
    wclk(Q);
    rb = sda_bus;
    wclk(Q);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input int kind);
    logic rb;
    logic exp_ack;
    exp_ack = (kind == K_ADDR) ? (b[7:1] == SADDR) : (kind != K_NONE);
    if (kind == K_DATA) exp_idx.push_back(m_ptr);
    for (int i = 7; i >= 0; i--) bit_slot(b[i], 1'b0, rb);
    if (kind == K_ADDR && exp_ack) m_busy = 1'b1;
    if (kind == K_PTR) m_ptr = int'(b) % NREGS;
    if (kind == K_DATA) begin
      m_regs[m_ptr] = b;
      m_ptr = (m_ptr + 1) % NREGS;
    end
    bit_slot(1'b1, exp_ack, rb);
    chk(~rb == exp_ack, "ack", 32'(~rb), 32'(exp_ack));
    if (!rb) n_acks++;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] got);
    logic rb;
    logic [7:0] exp;
    exp   = m_regs[m_ptr];
    m_ptr = (m_ptr + 1) % NREGS;
    for (int i = 7; i >= 0; i--) begin
      bit_slot(1'b1, ~exp[i], rb);
      got[i] = rb;
    end
    chk(got == exp, "rdata", 32'(got), 32'(exp));
    bit_slot(~ack, 1'b0, rb);
  endtask

  task automatic start_c();
    wclk(Q); sda_m = 1'b1;
    wclk(Q); scl_m = 1'b1;
    wclk(Q); sda_m = 1'b0;
    wclk(Q); scl_m = 1'b0;
  endtask

  task automatic stop_c();
    wclk(Q); sda_m = 1'b0;
    wclk(Q); scl_m = 1'b1;
    wclk(Q); sda_m = 1'b1;
    wclk(2 * Q);
    m_busy = 1'b0;
  endtask

  task automatic check_seen(input int n, input int s [3], input string name);
    chk(seen_idx.size() == n, name, 32'(seen_idx.size()), 32'(n));
    if (seen_idx.size() == n)
      for (int k = 0; k < n; k++)
        chk(seen_idx[k] == s[k], name, 32'(seen_idx[k]), 32'(s[k]));
    seen_idx.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       rb;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_busy = 1'b0; m_oe = 1'b0; m_quiet = 1'b0; chk_slot = 1'b0;

    wclk(3);
    chk(sda_oe === 1'b0, "rst_sda_oe", 32'(sda_oe), 32'd0);
    chk(regs_out === 32'h0, "rst_regs_out", regs_out, 32'h0);
    chk(busy === 1'b0, "rst_busy", 32'(busy), 32'd0);
    chk(wr_strobe === 1'b0, "rst_wr_strobe", 32'(wr_strobe), 32'd0);
    reset = 1'b1;
    wclk(4);

    // Plain write: pointer 1, two data bytes.
    n_acks = 0;
    start_c();
    write_byte(8'hA0, K_ADDR);
    write_byte(8'h01, K_PTR);
    write_byte(8'h5A, K_DATA);
    write_byte(8'hC3, K_DATA);
    chk(busy === 1'b1, "t1_busy", 32'(busy), 32'd1);
    stop_c();
    chk(n_acks == 4, "t1_ack_count", 32'(n_acks), 32'd4);
    chk(regs_out === 32'h00C35A00, "t1_regs", regs_out, 32'h00C35A00);
    check_seen(2, '{1, 2, 0}, "t1_wr_index_seq");

    // Pointer write, repeated START, two-byte read.
    start_c();
    write_byte(8'hA0, K_ADDR);
    write_byte(8'h01, K_PTR);
    start_c();
    write_byte(8'hA1, K_ADDR);
    read_byte(1'b1, rd0);
    read_byte(1'b0, rd1);
    wclk(Q);
    chk(sda_oe === 1'b0, "t2_release", 32'(sda_oe), 32'd0);
    stop_c();
    chk(busy === 1'b0, "t2_busy_after_stop", 32'(busy), 32'd0);
    chk(rd0 == 8'h5A, "t2_rd0", 32'(rd0), 32'h5A);
    chk(rd1 == 8'hC3, "t2_rd1", 32'(rd1), 32'hC3);

    // Wrong address: bus must stay untouched.
    m_quiet = 1'b1;
    start_c();
    write_byte(8'hA2, K_ADDR);
    write_byte(8'h00, K_NONE);
    write_byte(8'hFF, K_NONE);
    stop_c();
    m_quiet = 1'b0;
    chk(busy === 1'b0, "t3_busy", 32'(busy), 32'd0);
    chk(regs_out === 32'h00C35A00, "t3_regs", regs_out, 32'h00C35A00);
    check_seen(0, '{0, 0, 0}, "t3_no_strobe");

    // Pointer wrap 3 -> 0 -> 1.
    start_c();
    write_byte(8'hA0, K_ADDR);
    write_byte(8'h03, K_PTR);
    write_byte(8'h11, K_DATA);
    write_byte(8'h22, K_DATA);
    write_byte(8'h33, K_DATA);
    stop_c();
    chk(regs_out === 32'h11C33322, "t4_regs", regs_out, 32'h11C33322);
    check_seen(3, '{3, 0, 1}, "t4_wr_index_seq");

    // Upper pointer bits ignored: 0xFE selects reg2.
    start_c();
    write_byte(8'hA0, K_ADDR);
    write_byte(8'hFE, K_PTR);
    write_byte(8'h9D, K_DATA);
    stop_c();
    chk(regs_out === 32'h119D3322, "t5_regs", regs_out, 32'h119D3322);
    check_seen(1, '{2, 0, 0}, "t5_wr_index_seq");

    // Reset in the middle of a data byte, then a fresh write.
    start_c();
    write_byte(8'hA0, K_ADDR);
    write_byte(8'h00, K_PTR);
    for (int i = 0; i < 4; i++) bit_slot(1'b1, 1'b0, rb);
    wclk(Q / 2);
    reset = 1'b0;
    #1;
    chk(sda_oe === 1'b0, "t6_async_sda_oe", 32'(sda_oe), 32'd0);
    chk(regs_out === 32'h0, "t6_async_regs", regs_out, 32'h0);
    chk(busy === 1'b0, "t6_async_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_busy = 1'b0;
    wclk(3);
    reset = 1'b1;
    wclk(Q); sda_m = 1'b1;
    wclk(Q); scl_m = 1'b1;
    wclk(2 * Q);
    start_c();
    write_byte(8'hA0, K_ADDR);
    write_byte(8'h02, K_PTR);
    write_byte(8'h77, K_DATA);
    stop_c();
    chk(regs_out === 32'h00770000, "t6_regs", regs_out, 32'h00770000);
    check_seen(1, '{2, 0, 0}, "t6_wr_index_seq");
    chk(exp_idx.size() == 0, "pending_strobes", 32'(exp_idx.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
